data_ram_ctrl: RTL



---
 rtl/data_ram_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: byte-addressed little-endian data RAM with sized loads/stores, error flagging and a clear sequencer.
// Define DATA_RAM_RD_REG_EN to register RD (one cycle of load latency).
module data_ram_ctrl #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 32,
    parameter int TEST_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE,
    input  logic              RE,
    input  logic [1:0]        SIZE,
    input  logic              US,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              clr,
    output logic [31:0]       RD,
    output logic              busy,
    output logic              err,
    output logic [15:0]       Test_Value
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t      r_state;
    logic [AW-1:0] r_cnt;
    logic        r_busy;
    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx, w_wr_idx;
    logic [31:0] w_word, w_load, w_rd, w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_lanes, w_be;
    logic        w_range, w_bad, w_store;

    assign w_idx   = A[AW+1:2];
    assign w_range = (A >> (AW + 2)) == '0;
    assign w_bad   = (SIZE == 2'b11) | ((SIZE == 2'b01) & A[0]) | ((SIZE == 2'b10) & |A[1:0]) | ~w_range;
    assign err     = (WE | RE) & ~r_busy & w_bad;
    assign w_store = WE & ~r_busy & ~err;
    assign busy    = r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == AW'(DEPTH - 1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end
        end else if (clr) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end
    end

    // The clear sequencer shares the write port; it owns it whenever busy.
    assign w_lanes  = (SIZE == 2'b00) ? 4'b0001 << A[1:0] :
                      (SIZE == 2'b01) ? (A[1] ? 4'b1100 : 4'b0011) :
                      (SIZE == 2'b10) ? 4'b1111 : 4'b0000;
    assign w_be     = r_busy ? 4'b1111 : (w_store ? w_lanes : 4'b0000);
    assign w_wr_idx = r_busy ? r_cnt : w_idx;
    assign w_wdata  = r_busy ? '0 :
                      (SIZE == 2'b00) ? {4{WD[7:0]}} :
                      (SIZE == 2'b01) ? {2{WD[15:0]}} : WD;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wdata[8*i +: 8];
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = 8'(w_word >> {A[1:0], 3'b000});
    assign w_half = 16'(w_word >> {A[1], 4'b0000});
    assign w_load = (SIZE == 2'b00) ? {{24{~US & w_byte[7]}}, w_byte} :
                    (SIZE == 2'b01) ? {{16{~US & w_half[15]}}, w_half} :
                    (SIZE == 2'b10) ? w_word : '0;
    assign w_rd   = (r_busy | err) ? '0 : w_load;

    assign Test_Value = r_busy ? '0 : r_mem[TEST_IDX][15:0];

`ifdef DATA_RAM_RD_REG_EN
    logic [31:0] r_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd <= '0;
        else      r_rd <= w_rd;
    end

    assign RD = r_rd;
`else
    assign RD = w_rd;
`endif
endmodule
